neo_spike_detector: RTL and testbench
=====================================

# neo_spike_detector

Downstream stage of the NEO energy operator. Consumes the stream of unsigned NEO energy samples and learns a noise-floor threshold from an initial training window. After training it detects supra-threshold events, reports each event's peak value and sample index, then enforces a refractory period. It feeds the spike-event path (sorting/telemetry) with one pulse per detected spike.

## Interface
- `M`, 16: width of the unsigned energy sample `e_data`.
- `LOG2_WIN`, 6: log2 of the training window length (64 samples).
- `REFRACT`, 30: refractory length, in accepted samples.
- `PEAK_MAX`, 16: maximum length of a peak, in samples, before a spike is forced out.
- `TS_W`, 32: width of the sample index.

Ports (clock and reset first):
- `Clk` in 1: single clock. All logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `e_valid` in 1: energy sample strobe. No backpressure.
- `e_data` in M: unsigned NEO energy sample.
- `scale` in 8: threshold multiplier, unsigned Q4.4.
- `armed` out 1: high while not in TRAIN.
- `threshold` out M+4: current threshold, unsigned.
- `spike_valid` out 1: one-cycle pulse per spike.
- `spike_peak` out M: peak energy of the reported spike.
- `spike_ts` out TS_W: sample index of the peak.

## Operation
- **Reset:** state TRAIN; all counters, accumulator, peak registers and every output are 0.
- **Sample index:** `idx` increments on every accepted sample (`e_valid`=1), in all states. It starts at 0 after reset and wraps modulo 2^TS_W.
- **TRAIN:**
  - Accumulate `e_data` into an accumulator of M+LOG2_WIN bits, with no overflow possible.
  - On the 2^LOG2_WIN-th sample: mean = acc>>LOG2_WIN, threshold = (mean*scale)>>4, truncated to M+4 bits.
  - `scale` is sampled on that cycle only. Next state is ARMED.
- **ARMED:** an accepted sample with `e_data` > `threshold` (strictly greater) moves to PEAK. Peak is set to that sample, peak_ts to its idx, and len to 1.
- **PEAK:**
  - An accepted sample above threshold increments len.
  - If that sample is greater than peak, it replaces peak and peak_ts. A sample equal to peak keeps the earlier ts.
  - Exit on the first accepted sample ≤ threshold, or when len reaches PEAK_MAX after an update.
  - On exit: pulse `spike_valid` with `spike_peak`/`spike_ts`, then go to REFRACT with rcnt = REFRACT.
  - The exit sample is not a candidate peak.
- **REFRACT:** each accepted sample decrements rcnt and is otherwise ignored. When rcnt reaches 0 (on that sample), go to ARMED; the next sample can trigger.
- **`scale` = 0:** threshold is 0, so any nonzero sample triggers and 0 never does.
- **`spike_peak`/`spike_ts`:** hold their last values between pulses.

## Timing
- Every state transition and output update is registered one cycle after the accepting `Clk` edge.
- `armed` and `threshold` become valid in the cycle after the last training sample is accepted.
- `spike_valid` is high for exactly one cycle, in the cycle after the terminating sample is accepted.
- `e_valid` may be high every cycle or sparse. Latency is counted in accepted samples, not cycles.
- `reset` mid-operation: the next cycle is TRAIN with all outputs 0. An in-progress PEAK is discarded and never reported.

## Configuration
- **`NEO_THR_ADAPT_EN`:**
  - Defined: in ARMED and REFRACT, every accepted sample ≤ threshold updates mean += (e_data − mean)>>LOG2_WIN as a signed, arithmetic update. `threshold` is recomputed with the latched `scale` and takes effect from the next sample. PEAK samples and samples above threshold never adapt the mean.
  - Undefined: the threshold is frozen after TRAIN until reset.

## Test plan
- **Training:** 64 samples of 100, `scale`=0x30 → `armed` rises 1 cycle after the 64th sample; `threshold`=300. No `spike_valid` during TRAIN, even for a sample of 5000.
- **Basic spike:** after training, feed 250, 400, 900, 600, 200 at idx 64–68 → one `spike_valid` pulse after idx 68, with `spike_peak`=900 and `spike_ts`=66. A sample of exactly 300 never triggers.
- **Refractory:** after that spike, feed a sample of 1000 as the 1st through 30th post-spike samples → ignored. A sample of 1000 as the 31st post-spike sample → enters PEAK.
- **PEAK_MAX:** 16 consecutive samples of 500 starting at idx k → forced spike after the 16th, with `spike_peak`=500 and `spike_ts`=k (tie keeps the earliest).
- **Reset mid-PEAK:** assert `reset` for 1 cycle during PEAK → no spike reported; `armed`=0, `threshold`=0; idx restarts at 0 and retraining completes normally.
- **Adaptation (macro defined):** after training at 100, 64 samples of 200 → `threshold` rises monotonically toward 600. With the macro undefined, it stays 300.

Source files
------------

// File: rtl/neo_spike_detector.sv
// neo_spike_detector: learns a noise-floor threshold from a training window of NEO
//   energy samples, then reports the peak value and sample index of each supra-threshold
//   event, followed by a refractory period.
// Latency: state, threshold and spike outputs are registered one cycle after the
//   accepting edge. A spike is reported in the cycle after its terminating sample.
// Backpressure: none. Every e_valid cycle is consumed, and gaps in e_valid are allowed.
// Optional feature: NEO_THR_ADAPT_EN enables slow tracking of the noise floor after training.
module neo_spike_detector #(
    parameter int M        = 16,
    parameter int LOG2_WIN = 6,
    parameter int REFRACT  = 30,
    parameter int PEAK_MAX = 16,
    parameter int TS_W     = 32
) (
    input  logic            Clk,
    input  logic            reset,
    input  logic            e_valid,
    input  logic [M-1:0]    e_data,
    input  logic [7:0]      scale,
    output logic            armed,
    output logic [M+3:0]    threshold,
    output logic            spike_valid,
    output logic [M-1:0]    spike_peak,
    output logic [TS_W-1:0] spike_ts
);

    localparam int LEN_W = $clog2(PEAK_MAX + 1);
    localparam int RC_W  = $clog2(REFRACT + 1);
    localparam int ACC_W = M + LOG2_WIN;

    localparam logic [LEN_W-1:0] PEAK_MAX_L = LEN_W'(PEAK_MAX);
    localparam logic [RC_W-1:0]  REFRACT_L  = RC_W'(REFRACT);

    typedef enum logic [1:0] {
        S_TRAIN   = 2'd0,
        S_ARMED   = 2'd1,
        S_PEAK    = 2'd2,
        S_REFRACT = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [TS_W-1:0]     idx;
    logic [LOG2_WIN-1:0] train_cnt;
    logic [ACC_W-1:0]    acc;
    logic [M+3:0]        thr;
    logic [M-1:0]        peak;
    logic [TS_W-1:0]     peak_ts;
    logic [LEN_W-1:0]    len;
    logic [RC_W-1:0]     rcnt;

    logic [ACC_W-1:0]    acc_sum;
    logic [M-1:0]        mean_train;
    logic                train_done;
    logic                above;
    logic [LEN_W-1:0]    len_inc;
    logic                upd_peak;
    logic                forced;
    logic                exit_peak;
    logic [M-1:0]        peak_cand;
    logic [TS_W-1:0]     ts_cand;
    logic                adapt;
    logic [M+3:0]        thr_adapt;
    logic                spike_fire;

    // Threshold is (mean * scale) >> 4. The full product is M+8 bits, so the shift leaves exactly M+4.
    function automatic logic [M+3:0] thr_calc(input logic [M-1:0] m, input logic [7:0] s);
        logic [M+7:0] prod;
        prod = {8'b0, m} * {{M{1'b0}}, s};
        return prod[M+7:4];
    endfunction

    // Datapath decode shared by the FSM and the registers.
    always_comb begin
        acc_sum    = acc + {{LOG2_WIN{1'b0}}, e_data};
        mean_train = acc_sum[ACC_W-1:LOG2_WIN];
        train_done = e_valid && (state == S_TRAIN) && (&train_cnt);
        above      = ({4'b0, e_data} > thr);
        len_inc    = len + LEN_W'(1);
        upd_peak   = above && (e_data > peak);
        forced     = above && (len_inc == PEAK_MAX_L);
        exit_peak  = e_valid && (state == S_PEAK) && (!above || forced);
        peak_cand  = upd_peak ? e_data : peak;
        ts_cand    = upd_peak ? idx : peak_ts;
    end

`ifdef NEO_THR_ADAPT_EN
    logic [M-1:0]     mean;
    logic [7:0]       scale_lat;
    logic signed [M:0] diff;
    logic signed [M:0] step;
    logic signed [M:0] mean_sum;
    logic [M-1:0]     mean_new;

    // Below-threshold samples nudge the mean by (e - mean) >>> LOG2_WIN, an arithmetic shift.
    always_comb begin
        adapt     = e_valid && ((state == S_ARMED) || (state == S_REFRACT)) && !above;
        diff      = $signed({1'b0, e_data}) - $signed({1'b0, mean});
        step      = diff >>> LOG2_WIN;
        mean_sum  = $signed({1'b0, mean}) + step;
        mean_new  = mean_sum[M-1:0];
        thr_adapt = thr_calc(mean_new, scale_lat);
    end

    // The noise-floor mean and the scale captured at the end of training.
    always_ff @(posedge Clk) begin
        if (reset) begin
            mean      <= '0;
            scale_lat <= '0;
        end else if (train_done) begin
            mean      <= mean_train;
            scale_lat <= scale;
        end else if (adapt) begin
            mean      <= mean_new;
        end
    end
`else
    // The threshold is frozen once training completes.
    always_comb begin
        adapt     = 1'b0;
        thr_adapt = thr;
    end
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (reset) state <= S_TRAIN;
        else       state <= state_nxt;
    end

    // Next-state logic. Only accepted samples advance the FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            S_TRAIN:   if (train_done)                     state_nxt = S_ARMED;
            S_ARMED:   if (e_valid && above)               state_nxt = S_PEAK;
            S_PEAK:    if (exit_peak)                      state_nxt = S_REFRACT;
            S_REFRACT: if (e_valid && (rcnt <= RC_W'(1)))  state_nxt = S_ARMED;
            default:                                       state_nxt = S_TRAIN;
        endcase
    end

    // Output decode: armed comes from the state, and a spike fires on the exit from PEAK.
    always_comb begin
        armed      = (state != S_TRAIN);
        spike_fire = exit_peak;
    end

    assign threshold = thr;

    // Sample index. It counts every accepted sample in every state and wraps naturally.
    always_ff @(posedge Clk) begin
        if (reset)        idx <= '0;
        else if (e_valid) idx <= idx + TS_W'(1);
    end

    // Training accumulator and window counter. The accumulator is cleared for a later retrain.
    always_ff @(posedge Clk) begin
        if (reset) begin
            acc       <= '0;
            train_cnt <= '0;
        end else if (e_valid && (state == S_TRAIN)) begin
            acc       <= train_done ? '0 : acc_sum;
            train_cnt <= train_cnt + LOG2_WIN'(1);
        end
    end

    // Threshold register: loaded at the end of training, and optionally refined afterwards.
    always_ff @(posedge Clk) begin
        if (reset)           thr <= '0;
        else if (train_done) thr <= thr_calc(mean_train, scale);
        else if (adapt)      thr <= thr_adapt;
    end

    // Peak tracking. On a tie, the earlier index is kept because the compare is strict.
    always_ff @(posedge Clk) begin
        if (reset) begin
            peak    <= '0;
            peak_ts <= '0;
            len     <= '0;
        end else if (e_valid && (state == S_ARMED) && above) begin
            peak    <= e_data;
            peak_ts <= idx;
            len     <= LEN_W'(1);
        end else if (e_valid && (state == S_PEAK) && above) begin
            peak    <= peak_cand;
            peak_ts <= ts_cand;
            len     <= len_inc;
        end
    end

    // Refractory counter. It is loaded on the spike exit and counts down on accepted samples.
    always_ff @(posedge Clk) begin
        if (reset) begin
            rcnt <= '0;
        end else if (exit_peak) begin
            rcnt <= REFRACT_L;
        end else if (e_valid && (state == S_REFRACT) && (rcnt != '0)) begin
            rcnt <= rcnt - RC_W'(1);
        end
    end

    // Spike report. The pulse lasts one cycle, and peak/ts hold until the next spike.
    // A forced exit includes its final sample's update in the report.
    always_ff @(posedge Clk) begin
        if (reset) begin
            spike_valid <= 1'b0;
            spike_peak  <= '0;
            spike_ts    <= '0;
        end else begin
            spike_valid <= spike_fire;
            if (spike_fire) begin
                spike_peak <= peak_cand;
                spike_ts   <= ts_cand;
            end
        end
    end

endmodule

// File: tb/tb_neo_spike_detector.sv
// tb_neo_spike_detector: directed stimulus for neo_spike_detector. Expected spikes are
//   queued when their terminating sample is driven and are compared on each spike_valid.
// Inputs change #1 after the rising edge; outputs are sampled at #1 or on the falling edge.
module tb_neo_spike_detector;

    logic        Clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [15:0] e_data;
    logic [7:0]  scale;
    logic        armed;
    logic [19:0] threshold;
    logic        spike_valid;
    logic [15:0] spike_peak;
    logic [31:0] spike_ts;

    int          errors = 0;
    int          checks = 0;
    int unsigned tb_idx = 0;

    typedef struct packed {
        logic [15:0] peak;
        logic [31:0] ts;
    } spk_t;
    spk_t exp_q[$];

    neo_spike_detector dut (
        .Clk         (Clk),
        .reset       (reset),
        .e_valid     (e_valid),
        .e_data      (e_data),
        .scale       (scale),
        .armed       (armed),
        .threshold   (threshold),
        .spike_valid (spike_valid),
        .spike_peak  (spike_peak),
        .spike_ts    (spike_ts)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one accepted sample for a single cycle.
    task automatic send(input logic [15:0] d);
        e_valid = 1'b1;
        e_data  = d;
        @(posedge Clk);
        #1;
        e_valid = 1'b0;
        tb_idx++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic expect_spike(input logic [15:0] p, input logic [31:0] ts);
        spk_t s;
        s.peak = p;
        s.ts   = ts;
        exp_q.push_back(s);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge Clk);
        #1;
        reset  = 1'b0;
        tb_idx = 0;
    endtask

    // Train for 64 samples of val, replacing sample number sp_at with sp_val.
    task automatic train(input logic [15:0] val, input logic [7:0] sc,
                         input int sp_at, input logic [15:0] sp_val);
        scale = sc;
        for (int i = 0; i < 64; i++) begin
            send((i == sp_at) ? sp_val : val);
            if (i == 62) chk("armed_before_last_train", armed, 0);
            if (sp_at == i) chk("no_spike_in_train", spike_valid, 0);
        end
        chk("armed_after_train", armed, 1);
        scale = 8'hFF;
    endtask

    // Scoreboard: every pulse must match the oldest queued expectation.
    always @(negedge Clk) begin
        spk_t s;
        if (spike_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_spike: observed peak=%0d ts=%0d expected none",
                       spike_peak, spike_ts);
            end
            if (exp_q.size() != 0) begin
                s = exp_q.pop_front();
                chk("spike_peak", spike_peak, s.peak);
                chk("spike_ts", spike_ts, s.ts);
            end
        end
    end

    initial begin
        logic [19:0] prev_thr;
        reset   = 1'b1;
        e_valid = 1'b0;
        e_data  = '0;
        scale   = 8'h30;
        idle(2);
        chk("rst_armed", armed, 0);
        chk("rst_threshold", threshold, 0);
        chk("rst_spike_valid", spike_valid, 0);
        chk("rst_spike_peak", spike_peak, 0);
        chk("rst_spike_ts", spike_ts, 0);
        do_reset();

        // First training run: 64 samples of 100 with scale 3.0 give a threshold of 300.
        train(16'd100, 8'h30, -1, 16'd0);
        chk("train_threshold", threshold, 300);

        // Basic spike at indices 64 to 68, with an e_valid gap inside the peak.
        send(16'd250);
        send(16'd400);
        idle(3);
        send(16'd900);
        send(16'd600);
        expect_spike(16'd900, 32'd66);
        chk("idx_before_exit", tb_idx, 68);
        send(16'd200);
        chk("basic_spike_pulse", spike_valid, 1);
        idle(1);
        chk("pulse_one_cycle", spike_valid, 0);
        chk("peak_holds", spike_peak, 900);

        // Refractory: samples 1 to 30 after the spike are ignored, and sample 31 triggers.
        for (int i = 0; i < 30; i++) send(16'd1000);
        chk("refract_no_spike", spike_valid, 0);
        expect_spike(16'd1000, tb_idx);
        send(16'd1000);
        send(16'd100);
        chk("refract_then_spike", spike_valid, 1);

        // A sample exactly at the threshold never triggers.
        for (int i = 0; i < 30; i++) send(16'd0);
        send(16'd300);
        send(16'd300);
        send(16'd0);
        chk("equal_thr_no_spike", spike_valid, 0);

        // PEAK_MAX: 16 equal samples force a spike, and the tie keeps the first index.
        expect_spike(16'd500, tb_idx);
        for (int i = 0; i < 16; i++) send(16'd500);
        chk("forced_spike_pulse", spike_valid, 1);
        send(16'd500);
        chk("forced_pulse_one_cycle", spike_valid, 0);
        for (int i = 0; i < 29; i++) send(16'd0);

        // Reset during PEAK discards the event.
        send(16'd700);
        send(16'd800);
        do_reset();
        chk("rst_mid_armed", armed, 0);
        chk("rst_mid_threshold", threshold, 0);
        chk("rst_mid_spike_valid", spike_valid, 0);
        chk("rst_mid_spike_peak", spike_peak, 0);
        chk("rst_mid_spike_ts", spike_ts, 0);

        // Retrain with one 5000 sample: the mean is 11300 >> 6 = 176, so the threshold is 528.
        train(16'd100, 8'h30, 10, 16'd5000);
        chk("retrain_threshold", threshold, 528);
        expect_spike(16'd600, 32'd64);
        send(16'd600);
        send(16'd0);
        chk("retrain_idx_spike", spike_valid, 1);
        for (int i = 0; i < 30; i++) send(16'd0);

        // Threshold tracking with samples of 200 after training at 100.
        do_reset();
        train(16'd100, 8'h30, -1, 16'd0);
        chk("adapt_base_thr", threshold, 300);
        prev_thr = threshold;
        for (int i = 0; i < 64; i++) begin
            send(16'd200);
            chk("thr_monotonic", threshold >= prev_thr, 1);
            prev_thr = threshold;
        end
`ifdef NEO_THR_ADAPT_EN
        chk("thr_rises", (threshold > 300) && (threshold <= 600), 1);
`else
        chk("thr_frozen", threshold, 300);
`endif

        // scale = 0: the threshold is 0, so 0 never triggers and 1 does.
        do_reset();
        train(16'd100, 8'h00, -1, 16'd0);
        chk("scale0_threshold", threshold, 0);
        send(16'd0);
        send(16'd0);
        chk("scale0_zero_no_spike", spike_valid, 0);
        expect_spike(16'd1, tb_idx);
        send(16'd1);
        send(16'd0);
        chk("scale0_one_spikes", spike_valid, 1);

        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
